// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Shared types and helpers for the sound DDRAM path.
//   state_t  : byte-server FSM states
//   LANES    : bytes per 64-bit DDRAM word
//   lane_get : extract byte idx from a 64-bit line (byte 0 = bits [7:0])
//   lane_put : replace byte idx in a 64-bit line
// -----------------------------------------------------------------------------
package sound_pkg;

    localparam int unsigned LANES = 8;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        RD_CMD,
        RD_WAIT,
        WR_CMD
    } state_t;

    function automatic logic [7:0] lane_get(input logic [63:0] line,
                                            input logic [2:0]  idx);
        return line[idx*8 +: 8];
    endfunction

    function automatic logic [63:0] lane_put(input logic [63:0] line,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  data);
        logic [63:0] r;
        r = line;
        r[idx*8 +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/ddram_byte_server.sv
// -----------------------------------------------------------------------------
// ddram_byte_server
// Serves single-byte read/write requests (wave player, WAV loader) from the
// 64-bit DDRAM port using burst-length-1 transactions, with a one-line
// (8-byte) read cache so sequential byte fetches cost one DDRAM read per word.
//
// Ports:
//   I_CLK, I_RSTn          clock (clk_sys), async active-low reset
//   I_ADDR, I_RD, I_WE,    byte request; strobes sampled only while O_READY=1,
//   I_DIN                  write wins if both strobes are set
//   I_INV                  invalidate the cached line
//   O_DOUT, O_READY        read byte / idle-complete flag
//   DDRAM_*                64-bit DDRAM command/data port
// -----------------------------------------------------------------------------
module ddram_byte_server
    import sound_pkg::*;
#(
    parameter logic [28:0] BASE_WORD = 29'h0600_0000,
    parameter int unsigned ADDR_W    = 28
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic [ADDR_W-1:0] I_ADDR,
    input  logic              I_RD,
    input  logic              I_WE,
    input  logic [7:0]        I_DIN,
    input  logic              I_INV,
    output logic [7:0]        O_DOUT,
    output logic              O_READY,
    input  logic              DDRAM_BUSY,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic [28:0]       DDRAM_ADDR,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic              DDRAM_RD,
    output logic              DDRAM_WE,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE
);

    localparam int unsigned TAG_W = ADDR_W - 3;

    state_t            state;
    logic [63:0]       line;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  pend_tag;
    logic              valid;
    logic [2:0]        lane;

    logic [TAG_W-1:0]  req_word;
    logic [28:0]       req_ddr_addr;
    logic              req_hit;

    assign req_word       = I_ADDR[ADDR_W-1:3];
    assign req_ddr_addr   = BASE_WORD + 29'(req_word);
    assign req_hit        = valid && (tag == req_word);
    assign DDRAM_BURSTCNT = 8'd1;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state      <= IDLE;
            line       <= '0;
            tag        <= '0;
            pend_tag   <= '0;
            valid      <= 1'b0;
            lane       <= '0;
            O_DOUT     <= '0;
            O_READY    <= 1'b1;
            DDRAM_ADDR <= '0;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_WE) begin
                        O_READY    <= 1'b0;
                        DDRAM_WE   <= 1'b1;
                        DDRAM_ADDR <= req_ddr_addr;
                        DDRAM_DIN  <= {LANES{I_DIN}};
                        DDRAM_BE   <= 8'd1 << I_ADDR[2:0];
                        // write-through keeps the cached line coherent
                        if (req_hit)
                            line <= lane_put(line, I_ADDR[2:0], I_DIN);
                        state <= WR_CMD;
                    end else if (I_RD) begin
                        O_READY  <= 1'b0;
                        lane     <= I_ADDR[2:0];
                        pend_tag <= req_word;
                        if (req_hit) begin
                            state <= HIT;
                        end else begin
                            DDRAM_RD   <= 1'b1;
                            DDRAM_ADDR <= req_ddr_addr;
                            state      <= RD_CMD;
                        end
                    end
                end

                HIT: begin
                    O_DOUT  <= lane_get(line, lane);
                    O_READY <= 1'b1;
                    state   <= IDLE;
                end

                RD_CMD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        line    <= DDRAM_DOUT;
                        tag     <= pend_tag;
                        valid   <= 1'b1;
                        O_DOUT  <= lane_get(DDRAM_DOUT, lane);
                        O_READY <= 1'b1;
                        state   <= IDLE;
                    end
                end

                WR_CMD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        O_READY  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    O_READY  <= 1'b1;
                    DDRAM_RD <= 1'b0;
                    DDRAM_WE <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            // placed last so it overrides a fill completing on the same edge
            if (I_INV)
                valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddram_byte_server.sv
module tb_ddram_byte_server;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [27:0] i_addr = '0;
    logic        i_rd = 0, i_we = 0, i_inv = 0;
    logic [7:0]  i_din = '0;
    logic [7:0]  o_dout;
    logic        o_ready;
    logic        ddram_busy = 0;
    logic [63:0] ddram_dout = '0;
    logic        ddram_dout_ready = 0;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic        ddram_rd, ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;

    ddram_byte_server #(.BASE_WORD(29'h0600_0000), .ADDR_W(28)) dut (
        .I_CLK(clk), .I_RSTn(rst_n), .I_ADDR(i_addr), .I_RD(i_rd), .I_WE(i_we),
        .I_DIN(i_din), .I_INV(i_inv), .O_DOUT(o_dout), .O_READY(o_ready),
        .DDRAM_BUSY(ddram_busy), .DDRAM_DOUT(ddram_dout),
        .DDRAM_DOUT_READY(ddram_dout_ready), .DDRAM_ADDR(ddram_addr),
        .DDRAM_BURSTCNT(ddram_burstcnt), .DDRAM_RD(ddram_rd), .DDRAM_WE(ddram_we),
        .DDRAM_DIN(ddram_din), .DDRAM_BE(ddram_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
    } cmd_t;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
        int         low;   // exact low-cycle count expected, 0 = don't care
    } resp_t;

    cmd_t  exp_cmd_q[$];
    resp_t exp_resp_q[$];

    int errors = 0;
    int checks = 0;

    logic [63:0] rd_word = '0;
    int          rd_delay = 5;
    int          rd_high = 0;
    bit          rd_addr_chg = 0;
    logic [28:0] rd_addr_last = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // DDRAM read responder: data returns rd_delay cycles after the command is taken
    initial begin
        forever begin
            @(negedge clk);
            if (ddram_rd && !ddram_busy) begin
                @(posedge clk);
                repeat (rd_delay) @(posedge clk);
                #1;
                ddram_dout       = rd_word;
                ddram_dout_ready = 1;
                @(posedge clk);
                #1;
                ddram_dout_ready = 0;
            end
        end
    end

    // command monitor: one entry consumed per DDRAM command taken (cmd && !busy)
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (ddram_rd) begin
                rd_high++;
                if (rd_high > 1 && ddram_addr !== rd_addr_last) rd_addr_chg = 1;
                rd_addr_last = ddram_addr;
            end
            if ((ddram_rd || ddram_we) && !ddram_busy) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got rd=%0b we=%0b addr=%h expected none",
                             ddram_rd, ddram_we, ddram_addr);
                end else begin
                    c = exp_cmd_q.pop_front();
                    chk("cmd_we", {ddram_we, ddram_rd}, {c.we, !c.we});
                    chk("cmd_addr", ddram_addr, c.addr);
                    chk("cmd_burstcnt", ddram_burstcnt, 8'd1);
                    if (c.we) begin
                        chk("cmd_be", ddram_be, c.be);
                        chk("cmd_din", ddram_din, c.din);
                    end
                end
            end
        end
    end

    // response monitor: checks each ready rise against the queued expectation
    initial begin
        bit prev = 1;
        int low = 0;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1;
                low  = 0;
            end else if (!o_ready) begin
                low++;
                prev = 0;
            end else begin
                if (!prev) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got dout=%h expected none", o_dout);
                    end else begin
                        r = exp_resp_q.pop_front();
                        if (r.is_rd) chk("rd_dout", o_dout, r.data);
                        if (r.low != 0) chk("ready_low_cycles", low, r.low);
                    end
                end
                prev = 1;
                low  = 0;
            end
        end
    end

    task automatic issue_req(input bit rd, input bit we, input logic [27:0] a, input logic [7:0] d);
        i_rd = rd; i_we = we; i_addr = a; i_din = d;
        @(posedge clk); #1;
        i_rd = 0; i_we = 0;
        chk("ready_drop", o_ready, 1'b0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    task automatic push_cmd(input bit we, input logic [28:0] a, input logic [7:0] be, input logic [63:0] din);
        cmd_t c;
        c.we = we; c.addr = a; c.be = be; c.din = din;
        exp_cmd_q.push_back(c);
    endtask

    task automatic push_resp(input bit is_rd, input logic [7:0] d, input int low);
        resp_t r;
        r.is_rd = is_rd; r.data = d; r.low = low;
        exp_resp_q.push_back(r);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, o_ready, 1'b1);
        chk({tag, "_dout"}, o_dout, 8'h00);
        chk({tag, "_rd"}, ddram_rd, 1'b0);
        chk({tag, "_we"}, ddram_we, 1'b0);
        chk({tag, "_addr"}, ddram_addr, 29'h0);
        chk({tag, "_din"}, ddram_din, 64'h0);
        chk({tag, "_be"}, ddram_be, 8'h00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // 1: write A5 to byte 3 of word 0
        push_cmd(1, 29'h0600_0000, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5);
        push_resp(0, 8'h00, 0);
        issue_req(0, 1, 28'h000_0003, 8'hA5);
        wait_ready();

        // 2: cold read then sequential hit in the same line
        rd_word  = 64'h8877_6655_4433_2211;
        rd_delay = 5;
        push_cmd(0, 29'h0600_0002, 8'h00, 64'h0);
        push_resp(1, 8'h11, 0);
        issue_req(1, 0, 28'h000_0010, 8'h00);
        wait_ready();
        push_resp(1, 8'h66, 1);
        issue_req(1, 0, 28'h000_0015, 8'h00);
        wait_ready();

        // 4: write-through into the cached line, then hit on the written byte
        push_cmd(1, 29'h0600_0002, 8'h04, 64'hEEEE_EEEE_EEEE_EEEE);
        push_resp(0, 8'h00, 0);
        issue_req(0, 1, 28'h000_0012, 8'hEE);
        wait_ready();
        push_resp(1, 8'hEE, 1);
        issue_req(1, 0, 28'h000_0012, 8'h00);
        wait_ready();

        // 3: BUSY held for 4 edges during RD_CMD
        rd_word     = 64'h0102_0304_0506_0708;
        rd_delay    = 2;
        ddram_busy  = 1;
        push_cmd(0, 29'h0600_0008, 8'h00, 64'h0);
        push_resp(1, 8'h08, 0);
        rd_high     = 0;
        rd_addr_chg = 0;
        issue_req(1, 0, 28'h000_0040, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        ddram_busy = 0;
        wait_ready();
        chk("busy_rd_high_cycles", rd_high, 5);
        chk("busy_addr_stable", rd_addr_chg, 1'b0);

        // 5: RD and WE together -> write only; strobes while busy ignored
        push_cmd(1, 29'h0600_0004, 8'h02, 64'h5A5A_5A5A_5A5A_5A5A);
        push_resp(0, 8'h00, 0);
        issue_req(1, 1, 28'h000_0021, 8'h5A);
        wait_ready();
        ddram_busy = 1;
        push_cmd(1, 29'h0600_0006, 8'h01, 64'h7777_7777_7777_7777);
        push_resp(0, 8'h00, 0);
        issue_req(0, 1, 28'h000_0030, 8'h77);
        i_rd = 1; i_we = 1; i_addr = 28'h000_0008;
        repeat (2) @(posedge clk);
        #1;
        i_rd = 0; i_we = 0;
        ddram_busy = 0;
        wait_ready();
        repeat (3) @(posedge clk);
        #1;

        // 6: reset during RD_WAIT; late DOUT_READY must be ignored
        rd_word  = 64'hDEAD_BEEF_CAFE_F00D;
        rd_delay = 8;
        push_cmd(0, 29'h0600_0010, 8'h00, 64'h0);
        issue_req(1, 0, 28'h000_0080, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        rst_n = 1;
        repeat (12) @(posedge clk);
        #1;
        chk("late_fill_dout", o_dout, 8'h00);
        chk("late_fill_ready", o_ready, 1'b1);

        // cache was cleared by reset: previously cached word 8 misses
        rd_word  = 64'h0102_0304_0506_0708;
        rd_delay = 2;
        push_cmd(0, 29'h0600_0008, 8'h00, 64'h0);
        push_resp(1, 8'h08, 0);
        issue_req(1, 0, 28'h000_0040, 8'h00);
        wait_ready();
        push_resp(1, 8'h07, 1);
        issue_req(1, 0, 28'h000_0041, 8'h00);
        wait_ready();

        // invalidate, then the same address must miss again
        i_inv = 1;
        @(posedge clk); #1;
        i_inv = 0;
        push_cmd(0, 29'h0600_0008, 8'h00, 64'h0);
        push_resp(1, 8'h07, 0);
        issue_req(1, 0, 28'h000_0041, 8'h00);
        wait_ready();

        repeat (12) @(posedge clk);
        #1;
        chk("cmd_queue_drained", exp_cmd_q.size(), 0);
        chk("resp_queue_drained", exp_resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
